// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked shift-out, ACK check.
// Optional watchdog on device clock edges is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       FCLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  output logic [1:0] ERR_CODE,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [1:0]       sync1, sync2, filt;   // bit 0 = clock line, bit 1 = data line
  logic [FLT_W-1:0] flt_cnt [2];
  logic             fall;
  logic [INH_W-1:0] inh_cnt;
  logic [9:0]       frame;
  logic [3:0]       bit_cnt;

  // A level is accepted after FILTER_LEN consecutive differing samples; fall strobes with the update.
  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1      <= '1;
      sync2      <= '1;
      filt       <= '1;
      flt_cnt[0] <= '0;
      flt_cnt[1] <= '0;
      fall       <= 1'b0;
    end else begin
      sync1 <= {PS2_DATA_IN, PS2_CLK_IN};
      sync2 <= sync1;
      fall  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
          if (i == 0 && !sync2[i]) fall <= 1'b1;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (state == S_SHIFT || state == S_ACK || state == S_WAIT_IDLE) &&
                      !fall && (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt <= '0;
    end else if (state == S_IDLE || state == S_INHIBIT || fall) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      inh_cnt     <= '0;
      frame       <= '0;
      bit_cnt     <= '0;
      TX_READY    <= 1'b1;
      BUSY        <= 1'b0;
      TX_DONE     <= 1'b0;
      TX_ERR      <= 1'b0;
      ERR_CODE    <= '0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
    end else begin
      TX_DONE  <= 1'b0;
      TX_ERR   <= 1'b0;
      ERR_CODE <= '0;
      case (state)
        S_IDLE: begin
          PS2_CLK_OE  <= 1'b0;
          PS2_DATA_OE <= 1'b0;
          if (TX_VALID) begin
            frame      <= {1'b1, ~^TX_DATA, TX_DATA};
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            PS2_CLK_OE <= 1'b1;
            TX_READY   <= 1'b0;
            BUSY       <= 1'b1;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b1;
            state       <= S_RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        S_RTS: state <= S_SHIFT;
        S_SHIFT: begin
          // frame holds d0..d7, parity, stop; stop=1 releases the line
          if (fall) begin
            PS2_DATA_OE <= ~frame[0];
            frame       <= {1'b1, frame[9:1]};
            bit_cnt     <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd9) state <= S_ACK;
          end
        end
        S_ACK: begin
          if (fall) begin
            if (!filt[1]) begin
              state <= S_WAIT_IDLE;
            end else begin
              TX_ERR      <= 1'b1;
              ERR_CODE    <= 2'b01;
              PS2_CLK_OE  <= 1'b0;
              PS2_DATA_OE <= 1'b0;
              BUSY        <= 1'b0;
              TX_READY    <= 1'b1;
              state       <= S_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (filt == 2'b11) begin
            TX_DONE  <= 1'b1;
            BUSY     <= 1'b0;
            TX_READY <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (wd_expired) begin
        TX_DONE     <= 1'b0;
        TX_ERR      <= 1'b1;
        ERR_CODE    <= 2'b10;
        PS2_CLK_OE  <= 1'b0;
        PS2_DATA_OE <= 1'b0;
        BUSY        <= 1'b0;
        TX_READY    <= 1'b1;
        state       <= S_IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain line model, behavioural PS/2 device, frame reference model.
module tb_ps2_host_transmitter;

  localparam int INH = 20;
  localparam int FLT = 4;
  localparam int TO  = 2000;
  localparam int T   = 20;   // device clock half period in FCLK cycles

  logic       FCLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [7:0] TX_DATA = '0;
  logic       TX_VALID = 1'b0;
  logic       TX_READY, BUSY, TX_DONE, TX_ERR;
  logic [1:0] ERR_CODE;
  logic       PS2_CLK_OE, PS2_DATA_OE;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(PS2_CLK_OE | dev_clk_low);
  assign ps2_data_line = ~(PS2_DATA_OE | dev_data_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN(FLT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .FCLK(FCLK), .RST_N(RST_N), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .BUSY(BUSY), .TX_DONE(TX_DONE), .TX_ERR(TX_ERR),
    .ERR_CODE(ERR_CODE), .PS2_CLK_IN(ps2_clk_line), .PS2_DATA_IN(ps2_data_line),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE)
  );

  always #5 FCLK = ~FCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge FCLK) cyc++;

  int   low_run = 0, last_low = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   busy_bad = 0, pulse_busy_bad = 0, code_stick = 0;
  int   done_cyc = 0, oe_rise_cyc = 0, last_fall_cyc = 0;
  logic [1:0] last_code = '0;
  logic prev_err = 1'b0, prev_clk_oe = 1'b0;

  always @(negedge FCLK) begin
    if (PS2_CLK_OE === 1'b1) low_run++;
    else if (low_run != 0) begin last_low = low_run; low_run = 0; end
    if (PS2_CLK_OE === 1'b1 && prev_clk_oe !== 1'b1) oe_rise_cyc = cyc;
    prev_clk_oe = PS2_CLK_OE;
    if (TX_DONE === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (TX_ERR === 1'b1) begin err_cnt++; last_code = ERR_CODE; end
    if (TX_DONE === 1'b1 && TX_ERR === 1'b1) both_cnt++;
    if ((TX_DONE === 1'b1 || TX_ERR === 1'b1) && BUSY !== 1'b0) pulse_busy_bad++;
    if (BUSY === TX_READY) busy_bad++;
    if (prev_err === 1'b1 && ERR_CODE !== 2'b00) code_stick++;
    prev_err = TX_ERR;
  end

  // Reference: start 0, data LSB first, parity making total ones odd, stop 1.
  function automatic logic [10:0] expect_bits(input logic [7:0] b);
    logic [10:0] e;
    e[0] = 1'b0;
    for (int i = 0; i < 8; i++) e[i+1] = b[i];
    e[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    e[10] = 1'b1;
    return e;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge FCLK);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (TX_READY !== 1'b1 && n < 200) begin @(negedge FCLK); n++; end
    checks++;
    if (TX_READY !== 1'b1) begin
      errors++; ok = 1'b0;
      $display("FAIL ready_wait got %b want 1", TX_READY);
      return;
    end
    TX_DATA  = b;
    TX_VALID = 1'b1;
    @(negedge FCLK);
    TX_VALID = 1'b0;
    checks++;
    if (PS2_CLK_OE !== 1'b1) begin
      errors++; $display("FAIL accept_clk_oe got %b want 1", PS2_CLK_OE);
    end
    checks++;
    if (BUSY !== 1'b1 || TX_READY !== 1'b0) begin
      errors++; $display("FAIL accept_busy got busy=%b ready=%b want busy=1 ready=0", BUSY, TX_READY);
    end
  endtask

  // Device: waits for request-to-send, generates n_edges clock pulses, samples on rising edges,
  // and on the 11th pulse pulls data low as ACK when ack is set.
  task automatic device(input int n_edges, input bit ack, output logic [10:0] seen, output bit ok);
    int n;
    seen = 'x;
    ok = 1'b1;
    n = 0;
    while (!(ps2_data_line === 1'b0 && ps2_clk_line === 1'b1) && n < INH + 100) begin
      @(negedge FCLK); n++;
    end
    checks++;
    if (!(ps2_data_line === 1'b0 && ps2_clk_line === 1'b1)) begin
      errors++; ok = 1'b0;
      $display("FAIL rts_wait got clk=%b data=%b want clk=1 data=0", ps2_clk_line, ps2_data_line);
      return;
    end
    seen[0] = ps2_data_line;
    wait_cycles(T);
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) begin dev_data_low = ack; wait_cycles(T); end
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      wait_cycles(T);
      if (k <= 10) seen[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      wait_cycles(T);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input string name);
    int d0, e0, n;
    bit ok;
    logic [10:0] seen;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b, ok);
    if (!ok) return;
    device(11, ack, seen, ok);
    if (!ok) return;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin @(negedge FCLK); n++; end
    wait_cycles(2);
    checks++;
    if (seen !== expect_bits(b)) begin
      errors++; $display("FAIL %s_bits byte %h got %b want %b", name, b, seen, expect_bits(b));
    end
    checks++;
    if (last_low != INH) begin
      errors++; $display("FAIL %s_inhibit got %0d want %0d", name, last_low, INH);
    end
    if (ack) begin
      checks++;
      if (done_cnt != d0 + 1 || err_cnt != e0) begin
        errors++; $display("FAIL %s_done got done=%0d err=%0d want done=%0d err=%0d", name, done_cnt - d0, err_cnt - e0, 1, 0);
      end
    end else begin
      checks++;
      if (err_cnt != e0 + 1 || done_cnt != d0 || last_code !== 2'b01) begin
        errors++; $display("FAIL %s_nack got err=%0d done=%0d code=%b want err=1 done=0 code=01", name, err_cnt - e0, done_cnt - d0, last_code);
      end
    end
    checks++;
    if (PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0 || TX_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL %s_idle got oe=%b%b ready=%b busy=%b want oe=00 ready=1 busy=0", name, PS2_CLK_OE, PS2_DATA_OE, TX_READY, BUSY);
    end
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    wait_cycles(2);
    checks++;
    if (PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0 || TX_DONE !== 1'b0 || TX_ERR !== 1'b0 || ERR_CODE !== 2'b00 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_values got oe=%b%b done=%b err=%b code=%b busy=%b want all 0", PS2_CLK_OE, PS2_DATA_OE, TX_DONE, TX_ERR, ERR_CODE, BUSY);
    end
    RST_N = 1'b1;
    wait_cycles(2);
    checks++;
    if (TX_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_ready got ready=%b busy=%b want ready=1 busy=0", TX_READY, BUSY);
    end
  endtask

  task automatic test_send_ed(); run_frame(8'hED, 1'b1, "send_ed"); wait_cycles(10); endtask
  task automatic test_send_f4(); run_frame(8'hF4, 1'b1, "send_f4"); wait_cycles(10); endtask
  task automatic test_nack();    run_frame(8'h01, 1'b0, "nack");    wait_cycles(10); endtask

  task automatic test_random();
    logic [7:0] b;
    bit ack;
    for (int i = 0; i < 4; i++) begin
      b   = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) != 0);
      run_frame(b, ack, "random");
      wait_cycles(10);
    end
  endtask

  task automatic test_timeout();
    int d0, e0, n;
    bit ok;
    logic [10:0] seen;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'($urandom_range(0, 255)), ok);
    if (!ok) return;
    device(4, 1'b1, seen, ok);
    if (!ok) return;
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (err_cnt == e0 && n < TO + 200) begin @(negedge FCLK); n++; end
    n = cyc - last_fall_cyc;
    checks++;
    if (err_cnt != e0 + 1 || last_code !== 2'b10) begin
      errors++; $display("FAIL timeout_err got err=%0d code=%b want err=1 code=10", err_cnt - e0, last_code);
    end
    checks++;
    if (n < TO + 5 || n > TO + 10) begin
      errors++; $display("FAIL timeout_delay got %0d want %0d..%0d", n, TO + 5, TO + 10);
    end
    wait_cycles(2);
    checks++;
    if (TX_READY !== 1'b1 || PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0 || done_cnt != d0) begin
      errors++; $display("FAIL timeout_idle got ready=%b oe=%b%b done=%0d want ready=1 oe=00 done=0", TX_READY, PS2_CLK_OE, PS2_DATA_OE, done_cnt - d0);
    end
`else
    n = 0;
    wait_cycles(TO + 500);
    checks++;
    if (err_cnt != e0 || done_cnt != d0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL stall_hold got err=%0d done=%0d busy=%b want err=0 done=0 busy=1", err_cnt - e0, done_cnt - d0, BUSY);
    end
    RST_N = 1'b0;
    wait_cycles(3);
    RST_N = 1'b1;
    wait_cycles(2);
    checks++;
    if (TX_READY !== 1'b1 || err_cnt != e0) begin
      errors++; $display("FAIL stall_recover got ready=%b err=%0d want ready=1 err=0", TX_READY, err_cnt - e0);
    end
`endif
    wait_cycles(10);
  endtask

  task automatic test_reset_mid_shift();
    int d0, e0;
    bit ok;
    logic [10:0] seen;
    send_byte(8'hED, ok);
    if (!ok) return;
    device(2, 1'b1, seen, ok);
    if (!ok) return;
    checks++;
    if (PS2_DATA_OE !== 1'b1) begin
      errors++; $display("FAIL midshift_d1 got data_oe=%b want 1", PS2_DATA_OE);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0) begin
      errors++; $display("FAIL midshift_async_oe got %b%b want 00", PS2_CLK_OE, PS2_DATA_OE);
    end
    wait_cycles(3);
    RST_N = 1'b1;
    wait_cycles(3);
    checks++;
    if (done_cnt != d0 || err_cnt != e0 || TX_READY !== 1'b1) begin
      errors++; $display("FAIL midshift_pulse got done=%0d err=%0d ready=%b want 0 0 1", done_cnt - d0, err_cnt - e0, TX_READY);
    end
    run_frame(8'hED, 1'b1, "after_reset");
    wait_cycles(10);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    logic [10:0] seen1, seen2;
    int d0, dc, n;
    bit ok;
    b1 = 8'($urandom_range(0, 255));
    b2 = ~b1;
    d0 = done_cnt;
    n = 0;
    while (TX_READY !== 1'b1 && n < 200) begin @(negedge FCLK); n++; end
    TX_DATA  = b1;
    TX_VALID = 1'b1;
    @(negedge FCLK);
    TX_DATA  = b2;
    device(11, 1'b1, seen1, ok);
    n = 0;
    while (done_cnt == d0 && n < 200) begin @(negedge FCLK); n++; end
    dc = done_cyc;
    n = 0;
    while (TX_READY !== 1'b0 && n < 10) begin @(negedge FCLK); n++; end
    TX_VALID = 1'b0;
    device(11, 1'b1, seen2, ok);
    n = 0;
    while (done_cnt < d0 + 2 && n < 200) begin @(negedge FCLK); n++; end
    wait_cycles(2);
    checks++;
    if (seen1 !== expect_bits(b1)) begin
      errors++; $display("FAIL held_first_bits got %b want %b", seen1, expect_bits(b1));
    end
    checks++;
    if (seen2 !== expect_bits(b2)) begin
      errors++; $display("FAIL held_second_bits got %b want %b", seen2, expect_bits(b2));
    end
    checks++;
    if (oe_rise_cyc <= dc) begin
      errors++; $display("FAIL held_accept_order got inhibit@%0d want after done@%0d", oe_rise_cyc, dc);
    end
    checks++;
    if (done_cnt != d0 + 2) begin
      errors++; $display("FAIL held_done_count got %0d want 2", done_cnt - d0);
    end
    wait_cycles(10);
  endtask

  task automatic test_invariants();
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL done_err_overlap got %0d want 0", both_cnt); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL busy_ready_complement got %0d want 0", busy_bad); end
    checks++;
    if (pulse_busy_bad != 0) begin errors++; $display("FAIL busy_at_pulse got %0d want 0", pulse_busy_bad); end
    checks++;
    if (code_stick != 0) begin errors++; $display("FAIL err_code_clear got %0d want 0", code_stick); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got stalled run want completion");
    $fatal(1, "bench stalled");
  end

  initial begin
    test_reset();
    test_send_ed();
    test_send_f4();
    test_nack();
    test_random();
    test_timeout();
    test_reset_mid_shift();
    test_back_to_back();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
